// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the multdiv issue/retire controller.
// Operator encoding and issue FSM states.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_EXEC,
    MD_RESP,
    MD_DRAIN
  } md_issue_fsm_e;

endpackage

// File: rtl/ibex_multdiv_issue.sv
// Issue/retire controller wrapped around the fast multdiv unit.
// Holds operands and enable until md_valid, with zero bypass and watchdog.
module ibex_multdiv_issue
  import ibex_pkg::*;
#(
  parameter bit          FastZero   = 1'b1,
  parameter int unsigned WdogCycles = 48
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_b_is_zero_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        busy_o,
  output logic        wdog_err_o
);

  localparam logic [5:0] WdogLast = 6'(WdogCycles - 1);

  md_issue_fsm_e state_q;
  logic [5:0]    wdog_cnt_q;
  logic          req_is_mul;
  logic          md_is_mul;
  logic          a_zero;
  logic          b_zero;
  logic          fast_hit;
  logic [31:0]   fast_res;
  logic          enabled;

  assign req_is_mul = (req_operator_i == MD_OP_MULL) ||
                      (req_operator_i == MD_OP_MULH);
  assign md_is_mul  = (md_operator_o == MD_OP_MULL) ||
                      (md_operator_o == MD_OP_MULH);
  assign a_zero     = (req_op_a_i == '0);
  assign b_zero     = (req_op_b_i == '0);

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (FastZero) begin
      unique case (1'b1)
        req_is_mul && (a_zero || b_zero): begin
          fast_hit = 1'b1;
        end
        (req_operator_i == MD_OP_DIV) && b_zero: begin
          fast_hit = 1'b1;
          fast_res = '1;
        end
        (req_operator_i == MD_OP_REM) && b_zero: begin
          fast_hit = 1'b1;
          fast_res = req_op_a_i;
        end
        default: ;
      endcase
    end
  end

  // Enable spans EXEC and DRAIN so the unit's FSM never loses phase.
  assign enabled     = (state_q == MD_EXEC) || (state_q == MD_DRAIN);
  assign mult_en_o   = enabled && md_is_mul;
  assign div_en_o    = enabled && !md_is_mul;
  assign req_ready_o = (state_q == MD_IDLE);
  assign rsp_valid_o = (state_q == MD_RESP);
  assign busy_o      = (state_q != MD_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= MD_IDLE;
      wdog_cnt_q       <= '0;
      md_operator_o    <= MD_OP_MULL;
      md_signed_mode_o <= '0;
      md_op_a_o        <= '0;
      md_op_b_o        <= '0;
      md_b_is_zero_o   <= 1'b0;
      rsp_result_o     <= '0;
      wdog_err_o       <= 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (req_valid_i) begin
            md_operator_o    <= req_operator_i;
            md_signed_mode_o <= req_signed_mode_i;
            md_op_a_o        <= req_op_a_i;
            md_op_b_o        <= req_op_b_i;
            md_b_is_zero_o   <= b_zero;
            wdog_cnt_q       <= '0;
            if (fast_hit) begin
              rsp_result_o <= fast_res;
              state_q      <= MD_RESP;
            end else begin
              state_q <= MD_EXEC;
            end
          end
        end
        MD_EXEC: begin
          if (md_valid_i) begin
            if (flush_i) begin
              state_q <= MD_IDLE;
            end else begin
              rsp_result_o <= md_result_i;
              state_q      <= MD_RESP;
            end
          end else if (wdog_cnt_q == WdogLast) begin
            wdog_err_o <= 1'b1;
            state_q    <= MD_IDLE;
          end else if (flush_i) begin
            wdog_cnt_q <= '0;
            state_q    <= MD_DRAIN;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + 6'd1;
          end
        end
        MD_RESP: begin
          if (rsp_ready_i || flush_i) begin
            state_q <= MD_IDLE;
          end
        end
        MD_DRAIN: begin
          if (md_valid_i) begin
            state_q <= MD_IDLE;
          end else if (wdog_cnt_q == WdogLast) begin
            wdog_err_o <= 1'b1;
            state_q    <= MD_IDLE;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + 6'd1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: directed and random ops
// against an arithmetic reference and a latency-model multdiv.
module tb_ibex_multdiv_issue;
  import ibex_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  md_op_e      req_operator_i = MD_OP_MULL;
  logic [1:0]  req_signed_mode_i = '0;
  logic [31:0] req_op_a_i = '0;
  logic [31:0] req_op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        mult_en_o;
  logic        div_en_o;
  md_op_e      md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic        md_b_is_zero_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic        busy_o;
  logic        wdog_err_o;

  int tests = 0;
  int fails = 0;
  int md_cnt = 0;
  bit md_hang = 1'b0;

  ibex_multdiv_issue dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i),
    .req_signed_mode_i(req_signed_mode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .flush_i(flush_i),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o),
    .md_operator_o(md_operator_o),
    .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_b_is_zero_o(md_b_is_zero_o),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o),
    .busy_o(busy_o), .wdog_err_o(wdog_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_res(
    md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b
  );
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb;
    bit sgn;
    ea = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    sgn = (sm == 2'b11);
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == '1)
          return 32'h8000_0000;
        return sgn ? 32'(sa / sb) : a / b;
      end
      default: begin
        if (b == 0) return a;
        if (sgn && a == 32'h8000_0000 && b == '1)
          return 32'd0;
        return sgn ? 32'(sa % sb) : a % b;
      end
    endcase
  endfunction

  function automatic int md_lat(md_op_e op);
    case (op)
      MD_OP_MULL: return 3;
      MD_OP_MULH: return 4;
      default:    return 37;
    endcase
  endfunction

  // Downstream unit: valid on its Nth consecutive enabled cycle.
  always @(posedge clk_i)
    md_cnt <= (mult_en_o || div_en_o) ? md_cnt + 1 : 0;

  assign md_valid_i = (mult_en_o || div_en_o) && !md_hang &&
                      (md_cnt == md_lat(md_operator_o) - 1);
  assign md_result_i = ref_res(md_operator_o, md_signed_mode_o,
                               md_op_a_o, md_op_b_o);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(
    string tag, md_op_e op, logic [1:0] sm,
    logic [31:0] a, logic [31:0] b, int bp
  );
    int lat, ens, exp_lat;
    bit fast;
    logic [31:0] exp, held;
    fast = (op inside {MD_OP_MULL, MD_OP_MULH} && (a == 0 || b == 0)) ||
           (op inside {MD_OP_DIV, MD_OP_REM} && b == 0);
    exp_lat = fast ? 1 : md_lat(op) + 1;
    exp = fast && op inside {MD_OP_MULL, MD_OP_MULH} ? 32'd0
                                                     : ref_res(op, sm, a, b);
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_operator_i = op;
    req_signed_mode_i = sm;
    req_op_a_i = a;
    req_op_b_i = b;
    tick();
    req_valid_i = 1'b0;
    chk({tag, ".opb"}, md_op_b_o, b);
    chk({tag, ".bz"}, 32'(md_b_is_zero_o), 32'(b == 0));
    lat = 1;
    ens = 0;
    while (!rsp_valid_o && lat < 100) begin
      if (mult_en_o || div_en_o) ens++;
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".ens"}, 32'(ens), 32'(exp_lat - 1));
    chk({tag, ".res"}, rsp_result_o, exp);
    held = rsp_result_o;
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, ".bpv"}, 32'(rsp_valid_o), 32'd1);
      chk({tag, ".bpr"}, rsp_result_o, held);
      chk({tag, ".bprdy"}, 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk({tag, ".done"}, 32'({rsp_valid_o, req_ready_o}), 32'b01);
  endtask

  initial begin
    int n, ens;
    md_op_e op;
    logic [1:0] sm;
    logic [31:0] a, b;

    tick();
    tick();
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    chk("rst.rsp", 32'({rsp_valid_o, rsp_result_o}), 32'd0);
    chk("rst.en", 32'({mult_en_o, div_en_o, busy_o, wdog_err_o}), 32'd0);
    chk("rst.opa", md_op_a_o, 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("rst.post", 32'(req_ready_o), 32'd1);

    run_op("mull", MD_OP_MULL, 2'b00, 32'd7, 32'd6, 0);
    run_op("mulh", MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 0);
    chk("mulh.val", rsp_result_o, 32'h4000_0000);
    run_op("div", MD_OP_DIV, 2'b11, -32'sd7, 32'd2, 0);
    chk("div.val", rsp_result_o, 32'hFFFF_FFFD);
    run_op("fz.mul", MD_OP_MULL, 2'b00, 32'd0, 32'd99, 0);
    run_op("fz.div", MD_OP_DIV, 2'b11, 32'd5, 32'd0, 0);
    chk("fz.div.val", rsp_result_o, 32'hFFFF_FFFF);
    run_op("fz.rem", MD_OP_REM, 2'b00, 32'h1234, 32'd0, 0);
    chk("fz.rem.val", rsp_result_o, 32'h1234);
    run_op("bp", MD_OP_MULL, 2'b00, 32'd11, 32'd13, 5);

    // Flush mid-divide: enable must persist until the unit finishes.
    req_valid_i = 1'b1;
    req_operator_i = MD_OP_DIV;
    req_signed_mode_i = 2'b00;
    req_op_a_i = 32'd1000;
    req_op_b_i = 32'd7;
    tick();
    req_valid_i = 1'b0;
    ens = 0;
    n = 0;
    for (int c = 1; c < 60; c++) begin
      flush_i = (c == 10);
      if (div_en_o) begin
        ens++;
        n = c;
      end
      if (rsp_valid_o) ens += 1000;
      tick();
    end
    flush_i = 1'b0;
    chk("flush.ens", 32'(ens), 32'd37);
    chk("flush.last", 32'(n), 32'd37);
    chk("flush.idle", 32'(busy_o), 32'd0);
    run_op("postfl", MD_OP_MULL, 2'b00, 32'd3, 32'd3, 0);
    chk("postfl.val", rsp_result_o, 32'd9);

    // Flush while a response is pending drops it.
    req_valid_i = 1'b1;
    req_operator_i = MD_OP_MULL;
    req_op_a_i = 32'd5;
    req_op_b_i = 32'd5;
    tick();
    req_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("rflush.v", 32'(rsp_valid_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("rflush.drop", 32'({rsp_valid_o, req_ready_o}), 32'b01);

    // Random ops, with zero operands mixed in.
    for (int t = 0; t < 24; t++) begin
      op = md_op_e'($urandom_range(3));
      sm = 2'($urandom_range(3));
      if (op inside {MD_OP_DIV, MD_OP_REM}) sm = {sm[0], sm[0]};
      a = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3) == 0) b = 32'hFFFF_FFFF;
      run_op("rnd", op, sm, a, b, int'($urandom_range(2)));
    end

    // Watchdog: the unit never answers.
    md_hang = 1'b1;
    req_valid_i = 1'b1;
    req_operator_i = MD_OP_DIV;
    req_op_a_i = 32'd100;
    req_op_b_i = 32'd7;
    tick();
    req_valid_i = 1'b0;
    ens = 0;
    n = 0;
    while (!wdog_err_o && n < 200) begin
      if (div_en_o) ens++;
      tick();
      n++;
    end
    chk("wdog.err", 32'(wdog_err_o), 32'd1);
    chk("wdog.ens", 32'(ens), 32'd48);
    chk("wdog.off", 32'({div_en_o, mult_en_o, busy_o}), 32'd0);
    tick();
    chk("wdog.sticky", 32'(wdog_err_o), 32'd1);
    md_hang = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("wdog.clr", 32'(wdog_err_o), 32'd0);
    run_op("final", MD_OP_MULL, 2'b01, 32'hFFFF_FFFF, 32'd4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
